// File: rtl/pcihellocore_fan_pwm_if.sv
// Avalon-MM slave bus bundle for the fan PWM / tachometer block.
interface pcihellocore_fan_pwm_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/pcihellocore_fan_pwm.sv
// Fan PWM generator with tachometer measurement and stall interrupt.
// Registers: 0 DUTY, 1 PRESCALE, 2 TACH (RO), 3 STATUS {fan_en_sync, irq_en, stall}.
// Optional macro FAN_PWM_SOFTSTART_EN: effective duty ramps one step per PWM
// period toward DUTY after fan enable; stall detection waits for the ramp.
module pcihellocore_fan_pwm #(
   parameter int unsigned TACH_WINDOW = 1000000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   pcihellocore_fan_pwm_if.slave  bus,
   input  logic                   fan_en,
   input  logic                   tach_in,
   output logic                   pwm_out,
   output logic                   stall_irq
);

   localparam int unsigned WIN_W    = $clog2(TACH_WINDOW);
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned DUTY_W   = 8;
   localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(TACH_WINDOW - 1);
   localparam logic [DUTY_W-1:0] PWM_LAST = DUTY_W'(254);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [1:0] ADDR_DUTY     = 2'd0;
   localparam logic [1:0] ADDR_PRESCALE = 2'd1;
   localparam logic [1:0] ADDR_TACH     = 2'd2;
   localparam logic [1:0] ADDR_STATUS   = 2'd3;

   // register file
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0]  prescale_q, prescale_d;
   logic              irq_en_q, irq_en_d;
   logic              stall_q, stall_d;
   logic [CNT_W-1:0]  tach_q, tach_d;
   logic [31:0]       rdata_q, rdata_d;

   // PWM datapath
   logic [CNT_W-1:0]  presc_cnt_q, presc_cnt_d;
   logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [DUTY_W-1:0] eff_duty_q, eff_duty_d;
   logic [DUTY_W-1:0] duty_cmp;
   logic              pwm_out_q, pwm_out_d;
   logic              fan_prev_q;
   logic              fan_meta_q, fan_sync_q;
   logic              tick, wrap, fan_rise;

   // tachometer datapath
   logic              tach_meta_q, tach_sync_q, tach_prev_q;
   logic              tach_pulse;
   logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
   logic [CNT_W-1:0]  pulse_sum;
   logic              win_end;
   logic              stall_set, stall_clr, stall_allowed;
   logic              stall_irq_q, stall_irq_d;

   logic              wr_en;
   logic              unused_wdata;

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign unused_wdata = ^bus.writedata[31:16];

   // Host writes to DUTY, PRESCALE and STATUS.irq_en; TACH is read-only
   always_comb begin
      duty_d     = duty_q;
      prescale_d = prescale_q;
      irq_en_d   = irq_en_q;
      if (wr_en) begin
         case (bus.address)
            ADDR_DUTY:     duty_d     = bus.writedata[DUTY_W-1:0];
            ADDR_PRESCALE: prescale_d = bus.writedata[CNT_W-1:0];
            ADDR_STATUS:   irq_en_d   = bus.writedata[1];
            default:       ;
         endcase
      end
   end

   // Prescaler and 255-step PWM counter; both parked at 0 while the fan is off
   always_comb begin
      tick        = (presc_cnt_q == prescale_q);
      fan_rise    = fan_en & ~fan_prev_q;
      wrap        = fan_en & tick & (pwm_cnt_q == PWM_LAST);
      presc_cnt_d = presc_cnt_q;
      pwm_cnt_d   = pwm_cnt_q;
      if (!fan_en) begin
         presc_cnt_d = '0;
         pwm_cnt_d   = '0;
      end else if (tick) begin
         presc_cnt_d = '0;
         pwm_cnt_d   = wrap ? '0 : pwm_cnt_q + DUTY_W'(1);
      end else begin
         presc_cnt_d = presc_cnt_q + CNT_W'(1);
      end
   end

   // Effective duty only changes at period boundaries or on fan enable
   always_comb begin
      eff_duty_d = eff_duty_q;
`ifdef FAN_PWM_SOFTSTART_EN
      if (fan_rise) begin
         eff_duty_d = '0;
      end else if (wrap) begin
         if (eff_duty_q < duty_q) begin
            eff_duty_d = eff_duty_q + DUTY_W'(1);
         end else if (eff_duty_q > duty_q) begin
            eff_duty_d = eff_duty_q - DUTY_W'(1);
         end
      end
`else
      if (fan_rise || wrap) begin
         eff_duty_d = duty_q;
      end
`endif
   end

   // PWM compare; on the enable edge use the freshly loaded duty so the
   // first period starts clean instead of with a stale value
   always_comb begin
      duty_cmp  = fan_rise ? eff_duty_d : eff_duty_q;
      pwm_out_d = fan_en & (pwm_cnt_q < duty_cmp);
   end

   // Tach pulse counting over a free-running measurement window
   always_comb begin
      tach_pulse  = tach_sync_q & ~tach_prev_q;
      win_end     = (win_cnt_q == WIN_LAST);
      win_cnt_d   = win_end ? '0 : win_cnt_q + WIN_W'(1);
      pulse_sum   = (tach_pulse && (pulse_cnt_q != CNT_MAX)) ?
                    pulse_cnt_q + CNT_W'(1) : pulse_cnt_q;
      pulse_cnt_d = win_end ? '0 : pulse_sum;
      tach_d      = win_end ? pulse_sum : tach_q;
   end

   // Sticky stall flag; a new stall event beats a simultaneous W1C
   always_comb begin
`ifdef FAN_PWM_SOFTSTART_EN
      stall_allowed = (eff_duty_q == duty_q);
`else
      stall_allowed = 1'b1;
`endif
      stall_set   = win_end & (pulse_sum == '0) & fan_en &
                    (eff_duty_q != '0) & stall_allowed;
      stall_clr   = wr_en & (bus.address == ADDR_STATUS) & bus.writedata[0];
      stall_d     = stall_set | (stall_q & ~stall_clr);
      stall_irq_d = stall_d & irq_en_d;
   end

   // Read mux, registered every cycle independent of chipselect
   always_comb begin
      rdata_d = '0;
      case (bus.address)
         ADDR_DUTY:     rdata_d = {24'd0, duty_q};
         ADDR_PRESCALE: rdata_d = {16'd0, prescale_q};
         ADDR_TACH:     rdata_d = {16'd0, tach_q};
         ADDR_STATUS:   rdata_d = {29'd0, fan_sync_q, irq_en_q, stall_q};
         default:       rdata_d = '0;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         duty_q      <= '1;
         prescale_q  <= '0;
         irq_en_q    <= 1'b0;
         stall_q     <= 1'b0;
         tach_q      <= '0;
         rdata_q     <= '0;
         presc_cnt_q <= '0;
         pwm_cnt_q   <= '0;
         eff_duty_q  <= '1;
         pwm_out_q   <= 1'b0;
         // track the live level so a fan held on through reset runs at full speed
         fan_prev_q  <= fan_en;
         fan_meta_q  <= 1'b0;
         fan_sync_q  <= 1'b0;
         tach_meta_q <= 1'b0;
         tach_sync_q <= 1'b0;
         tach_prev_q <= 1'b0;
         win_cnt_q   <= '0;
         pulse_cnt_q <= '0;
         stall_irq_q <= 1'b0;
      end else begin
         duty_q      <= duty_d;
         prescale_q  <= prescale_d;
         irq_en_q    <= irq_en_d;
         stall_q     <= stall_d;
         tach_q      <= tach_d;
         rdata_q     <= rdata_d;
         presc_cnt_q <= presc_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         eff_duty_q  <= eff_duty_d;
         pwm_out_q   <= pwm_out_d;
         fan_prev_q  <= fan_en;
         fan_meta_q  <= fan_en;
         fan_sync_q  <= fan_meta_q;
         tach_meta_q <= tach_in;
         tach_sync_q <= tach_meta_q;
         tach_prev_q <= tach_sync_q;
         win_cnt_q   <= win_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         stall_irq_q <= stall_irq_d;
      end
   end

   assign bus.readdata = rdata_q;
   assign pwm_out      = pwm_out_q;
   assign stall_irq    = stall_irq_q;

endmodule

// File: tb/tb_pcihellocore_fan_pwm.sv
// Directed self-checking bench for pcihellocore_fan_pwm (TACH_WINDOW = 1000).
module tb_pcihellocore_fan_pwm;
   localparam int TW = 1000;

   logic clk = 1'b0;
   logic reset_n;
   logic fan_en;
   logic tach_in;
   wire  pwm_out;
   wire  stall_irq;

   int checks = 0;
   int errors = 0;
   int cyc;

   pcihellocore_fan_pwm_if bus ();

   pcihellocore_fan_pwm #(.TACH_WINDOW(TW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .fan_en    (fan_en),
      .tach_in   (tach_in),
      .pwm_out   (pwm_out),
      .stall_irq (stall_irq)
   );

   always #5 clk = ~clk;

   // clock edges since reset release; window ends land on multiples of TW
   always @(posedge clk) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   // pwm_out run-length recorder
   logic mon_en = 1'b0;
   logic mon_last;
   int   mon_len;
   int   run_len_q[$];
   logic run_lvl_q[$];

   always @(negedge clk) begin
      if (mon_en) begin
         if (pwm_out === mon_last) begin
            mon_len++;
         end else begin
            run_len_q.push_back(mon_len);
            run_lvl_q.push_back(mon_last);
            mon_last = pwm_out;
            mon_len  = 1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mon_start();
      mon_en = 1'b0;
      run_len_q.delete();
      run_lvl_q.delete();
      mon_last = pwm_out;
      mon_len  = 0;
      mon_en   = 1'b1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus.address = a;
      @(negedge clk);
      d = bus.readdata;
   endtask

   task automatic wait_phase(input int ph, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * TW && !ok; i++) begin
         if ((cyc % TW) == ph) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic wait_cyc(input int target, output bit ok);
      for (int i = 0; i < 3 * TW && cyc < target; i++) @(negedge clk);
      ok = (cyc == target);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      int bad;
      reset_n = 1'b0;
      fan_en  = 1'b1;
      tick(3);
      checks++;
      if (bus.readdata !== 32'h0) begin
         errors++; $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
      end
      checks++;
      if (pwm_out !== 1'b0) begin
         errors++; $display("FAIL reset_pwm_out: got %b expected 0", pwm_out);
      end
      checks++;
      if (stall_irq !== 1'b0) begin
         errors++; $display("FAIL reset_stall_irq: got %b expected 0", stall_irq);
      end
      reset_n = 1'b1;
      tick(1);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         if (pwm_out !== 1'b1) bad++;
         tick(1);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL reset_full_speed: got %0d low samples expected 0", bad);
      end
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000_00FF) begin
         errors++; $display("FAIL reset_duty: got %h expected %h", rd, 32'hFF);
      end
      bus_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL reset_prescale: got %h expected %h", rd, 32'h0);
      end
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL reset_tach: got %h expected %h", rd, 32'h0);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h4) begin
         errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'h4);
      end
   endtask

   task automatic test_pwm_duty();
      logic [31:0] rd;
      int exp_len[4] = '{256, 764, 512, 508};
      logic exp_lvl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      fan_en = 1'b0;
      tick(2);
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'h1234_5640);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0000_0040) begin
         errors++; $display("FAIL duty_upper_bits: got %h expected %h", rd, 32'h40);
      end
      mon_start();
      fan_en = 1'b1;
      tick(150);
      // mid-period write must not disturb the running period
      bus_write(2'd0, 32'd128);
      for (int i = 0; i < 4000 && run_len_q.size() < 5; i++) tick(1);
      checks++;
      if (run_len_q.size() < 5) begin
         errors++; $display("FAIL pwm_timeout: got %0d runs expected 5", run_len_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (run_len_q[k+1] != exp_len[k] || run_lvl_q[k+1] !== exp_lvl[k]) begin
               errors++;
               $display("FAIL pwm_run%0d: got level %b len %0d expected level %b len %0d",
                        k, run_lvl_q[k+1], run_len_q[k+1], exp_lvl[k], exp_len[k]);
            end
         end
      end
      mon_en = 1'b0;
      fan_en = 1'b0;
      tick(1);
      checks++;
      if (pwm_out !== 1'b0) begin
         errors++; $display("FAIL fan_off_pwm: got %b expected 0", pwm_out);
      end
   endtask

`ifdef FAN_PWM_SOFTSTART_EN
   task automatic test_softstart();
      int bad;
      int exp_len[5] = '{1, 254, 2, 253, 3};
      fan_en = 1'b0;
      tick(2);
      bus_write(2'd1, 32'd0);
      bus_write(2'd0, 32'd3);
      mon_start();
      fan_en = 1'b1;
      for (int i = 0; i < 3000 && run_len_q.size() < 6; i++) tick(1);
      checks++;
      if (run_len_q.size() < 6) begin
         errors++; $display("FAIL ramp_timeout: got %0d runs expected 6", run_len_q.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (run_len_q[k+1] != exp_len[k]) begin
               errors++;
               $display("FAIL ramp_run%0d: got %0d expected %0d", k, run_len_q[k+1], exp_len[k]);
            end
         end
      end
      mon_en = 1'b0;
      fan_en = 1'b0;
      tick(2);
      fan_en = 1'b1;
      tick(300);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         if (pwm_out !== 1'b1) bad++;
         tick(1);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL ramp_reset_full: got %0d low samples expected 0", bad);
      end
   endtask
`endif

   task automatic test_fan_off();
      logic [31:0] rd;
      fan_en = 1'b0;
      tick(2);
      bus_write(2'd3, 32'h1);
      tick(TW + 100);
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL fan_off_status: got %h expected %h", rd, 32'h0);
      end
      checks++;
      if (stall_irq !== 1'b0) begin
         errors++; $display("FAIL fan_off_irq: got %b expected 0", stall_irq);
      end
   endtask

   task automatic test_tach();
      logic [31:0] rd;
      bit ok;
      int base;
      int offs[7] = '{10, 110, 210, 310, 410, 510, TW - 3};
      bus_write(2'd1, 32'd0);
      fan_en = 1'b1;
      wait_phase(0, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL tach_align: got timeout expected window end");
      end
      base = cyc;
      // the last pulse reaches the counter exactly on the window's final cycle
      foreach (offs[k]) begin
         wait_cyc(base + offs[k], ok);
         tach_in = 1'b1;
         tick(2);
         tach_in = 1'b0;
      end
      tick(5);
      bus_write(2'd2, 32'hABCD);
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'd7) begin
         errors++; $display("FAIL tach_count: got %h expected %h", rd, 32'd7);
      end
   endtask

   task automatic test_stall();
      logic [31:0] rd;
      bit ok;
      bus_write(2'd0, 32'd100);
      bus_write(2'd3, 32'h3);
      checks++;
      if (stall_irq !== 1'b0) begin
         errors++; $display("FAIL stall_pre_irq: got %b expected 0", stall_irq);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h6) begin
         errors++; $display("FAIL stall_pre_status: got %h expected %h", rd, 32'h6);
      end
      wait_phase(0, ok);
      checks++;
      if (!ok || stall_irq !== 1'b1) begin
         errors++; $display("FAIL stall_irq_set: got %b expected 1", stall_irq);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h7) begin
         errors++; $display("FAIL stall_status_set: got %h expected %h", rd, 32'h7);
      end
      bus_write(2'd3, 32'h3);
      checks++;
      if (stall_irq !== 1'b0) begin
         errors++; $display("FAIL stall_w1c_irq: got %b expected 0", stall_irq);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h6) begin
         errors++; $display("FAIL stall_w1c_status: got %h expected %h", rd, 32'h6);
      end
      // clear lands on the same edge as a new stall event
      wait_phase(TW - 1, ok);
      bus_write(2'd3, 32'h3);
      checks++;
      if (!ok || stall_irq !== 1'b1) begin
         errors++; $display("FAIL stall_set_wins_irq: got %b expected 1", stall_irq);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h7) begin
         errors++; $display("FAIL stall_set_wins_status: got %h expected %h", rd, 32'h7);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      bit ok;
      fan_en = 1'b1;
      wait_phase(100, ok);
      tach_in = 1'b1; tick(2); tach_in = 1'b0; tick(48);
      tach_in = 1'b1; tick(2); tach_in = 1'b0; tick(150);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(4);
      bus_read(2'd0, rd);
      checks++;
      if (rd !== 32'hFF) begin
         errors++; $display("FAIL midreset_duty: got %h expected %h", rd, 32'hFF);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h4 || stall_irq !== 1'b0) begin
         errors++; $display("FAIL midreset_status: got %h irq %b expected %h irq 0", rd, stall_irq, 32'h4);
      end
      tick(830);
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL midreset_tach_old_window: got %h expected %h", rd, 32'h0);
      end
      tick(200);
      bus_read(2'd2, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("FAIL midreset_tach_new_window: got %h expected %h", rd, 32'h0);
      end
      bus_read(2'd3, rd);
      checks++;
      if (rd !== 32'h5) begin
         errors++; $display("FAIL midreset_stall_new_window: got %h expected %h", rd, 32'h5);
      end
   endtask

   initial begin
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      reset_n        = 1'b0;
      fan_en         = 1'b1;
      tach_in        = 1'b0;
      @(negedge clk);
      test_reset();
`ifdef FAN_PWM_SOFTSTART_EN
      test_softstart();
`else
      test_pwm_duty();
`endif
      test_fan_off();
      test_tach();
`ifndef FAN_PWM_SOFTSTART_EN
      test_stall();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
